// File: rtl/ifetch_pair_if.sv
// Fetch-stage bundle: control inputs from PC/ctrl, SRAM read port and the
// entry handed to the instruction buffer.
interface ifetch_pair_if #(
  parameter int unsigned STALLBUS_WD = 6,
  parameter int unsigned BR_WD       = 33
);
  logic                   flush;
  logic [31:0]            new_pc;
  logic [STALLBUS_WD-1:0] stall;
  logic [BR_WD-1:0]       br_bus;
  logic                   inst_sram_en;
  logic [7:0]             inst_sram_wen;
  logic [31:0]            inst_sram_addr;
  logic [65:0]            if_to_ib_bus;

  modport master (
    input  flush, new_pc, stall, br_bus,
    output inst_sram_en, inst_sram_wen, inst_sram_addr, if_to_ib_bus
  );

  modport slave (
    output flush, new_pc, stall, br_bus,
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, if_to_ib_bus
  );
endinterface

// File: rtl/ifetch_pair.sv
// PC generator and 64-bit aligned instruction fetch; handles branch redirect
// (immediate or deferred under stall), flush and stall hold.
module ifetch_pair #(
  parameter int unsigned STALLBUS_WD = 6,
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
  parameter int unsigned BR_WD       = 33
) (
  input logic           clk,
  input logic           rst,
  ifetch_pair_if.master fe
);

  typedef enum logic [1:0] {StResetWait, StRun, StPendBr} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_target_q, pend_target_d;
  logic        ce_q, ce_d;
  logic        discard_q, discard_d;

  logic        stall_pc;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] pc_aligned;
  logic        unused_stall;

  assign stall_pc     = fe.stall[0];
  assign br_taken     = fe.br_bus[32];
  assign br_target    = fe.br_bus[31:0];
  assign pc_aligned   = {pc_q[31:3], 3'b000};
  // Upper stall bits are consumed by the buffer, not here.
  assign unused_stall = ^fe.stall[STALLBUS_WD-1:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StResetWait;
      pc_q          <= RESET_PC;
      pend_target_q <= 32'h0;
      ce_q          <= 1'b0;
      discard_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_target_q <= pend_target_d;
      ce_q          <= ce_d;
      discard_q     <= discard_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    ce_d          = ce_q;
    discard_d     = discard_q;
    if (fe.flush) begin
      state_d       = StRun;
      pc_d          = fe.new_pc;
      pend_target_d = 32'h0;
      ce_d          = 1'b1;
      discard_d     = 1'b0;
    end else begin
      unique case (state_q)
        StResetWait: begin
          ce_d    = 1'b1;
          state_d = StRun;
        end
        StRun, StPendBr: begin
          if (br_taken) begin
            if (!stall_pc) begin
              // Newest branch wins over any deferred one.
              pc_d      = br_target;
              discard_d = 1'b1;
              state_d   = StRun;
            end else begin
              pend_target_d = br_target;
              state_d       = StPendBr;
            end
          end else if (!stall_pc) begin
            if (state_q == StPendBr) begin
              pc_d      = pend_target_q;
              discard_d = 1'b1;
              state_d   = StRun;
            end else begin
              pc_d      = pc_aligned + 32'd8;
              discard_d = 1'b0;
            end
          end
        end
        default: state_d = StResetWait;
      endcase
    end
  end

  // Nothing is presented to SRAM or buffer until the first fetch is armed.
  always_comb begin
    fe.inst_sram_en   = 1'b0;
    fe.inst_sram_addr = 32'h0;
    fe.if_to_ib_bus   = 66'h0;
    if (state_q != StResetWait) begin
      fe.inst_sram_en   = ce_q & ~stall_pc;
      fe.inst_sram_addr = pc_aligned;
      fe.if_to_ib_bus   = {discard_q, ce_q, pc_q, pc_aligned};
    end
  end

  assign fe.inst_sram_wen = 8'h00;

endmodule

// File: tb/tb_ifetch_pair.sv
// Directed plus randomized bench for ifetch_pair against a behavioural fetch
// model (pending redirect kept as a queue).
module tb_ifetch_pair;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_pair_if #(.STALLBUS_WD(6), .BR_WD(33)) fe ();

  ifetch_pair #(.STALLBUS_WD(6), .RESET_PC(RST_PC), .BR_WD(33)) dut (
    .clk (clk),
    .rst (rst),
    .fe  (fe)
  );

  int n_vec  = 0;
  int n_chk  = 0;
  int n_fail = 0;

  // Reference model
  logic [31:0] m_pc;
  logic        m_ce;
  logic        m_disc;
  bit          m_armed;
  logic [31:0] m_pend[$];

  task automatic model_edge(input bit r, input bit f, input logic [31:0] np,
                            input logic [5:0] st, input logic [32:0] br);
    if (r) begin
      m_pc = RST_PC; m_ce = 1'b0; m_disc = 1'b0; m_armed = 1'b0; m_pend.delete();
    end else if (f) begin
      m_pc = np; m_ce = 1'b1; m_disc = 1'b0; m_armed = 1'b1; m_pend.delete();
    end else if (!m_armed) begin
      m_ce = 1'b1; m_armed = 1'b1;
    end else if (br[32]) begin
      m_pend.delete();
      if (!st[0]) begin
        m_pc = br[31:0]; m_disc = 1'b1;
      end else begin
        m_pend.push_back(br[31:0]);
      end
    end else if (!st[0]) begin
      if (m_pend.size() != 0) begin
        m_pc = m_pend.pop_front(); m_disc = 1'b1;
      end else begin
        m_pc = (m_pc & 32'hFFFF_FFF8) + 32'd8; m_disc = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [65:0] e_bus;
    logic        e_en;
    logic [31:0] e_addr;
    e_bus  = '0;
    e_en   = 1'b0;
    e_addr = '0;
    if (m_armed) begin
      e_addr = m_pc & 32'hFFFF_FFF8;
      e_en   = m_ce & ~fe.stall[0];
      e_bus  = {m_disc, m_ce, m_pc, e_addr};
    end
    chk("en", {65'h0, fe.inst_sram_en}, {65'h0, e_en});
    chk("wen", {58'h0, fe.inst_sram_wen}, 66'h0);
    chk("addr", {34'h0, fe.inst_sram_addr}, {34'h0, e_addr});
    chk("bus", fe.if_to_ib_bus, e_bus);
  endtask

  // Drive one cycle of inputs, check current outputs, then advance a clock.
  task automatic step(input bit r, input bit f, input logic [31:0] np,
                      input logic [5:0] st, input logic [32:0] br);
    rst       = r;
    fe.flush  = f;
    fe.new_pc = np;
    fe.stall  = st;
    fe.br_bus = br;
    #1;
    check_model();
    n_vec++;
    @(posedge clk);
    model_edge(r, f, np, st, br);
    #1;
  endtask

  task automatic free(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 6'h0, 33'h0);
  endtask

  initial begin
    logic [32:0] br;
    logic [5:0]  st;
    bit          r, f;
    logic [31:0] np;

    rst = 1'b1; fe.flush = 1'b0; fe.new_pc = '0; fe.stall = '0; fe.br_bus = '0;
    @(posedge clk);
    model_edge(1'b1, 1'b0, 32'h0, 6'h0, 33'h0);
    #1;

    // Reset cycle then free run
    step(1'b1, 1'b0, 32'h0, 6'h0, 33'h0);
    free(4);
    chk("seq_pc", {34'h0, fe.if_to_ib_bus[63:32]}, {34'h0, 32'hBFC0_0018});

    // Immediate taken branch
    step(1'b0, 1'b0, 32'h0, 6'h0, {1'b1, 32'hBFC0_0104});
    chk("br_pc_idef", {34'h0, fe.if_to_ib_bus[63:32]}, {34'h0, 32'hBFC0_0104});
    chk("br_ib_pc", {34'h0, fe.if_to_ib_bus[31:0]}, {34'h0, 32'hBFC0_0100});
    chk("br_discard", {65'h0, fe.if_to_ib_bus[65]}, 66'h1);
    free(1);
    chk("after_br_pc", {34'h0, fe.if_to_ib_bus[63:32]}, {34'h0, 32'hBFC0_0108});
    chk("after_br_disc", {65'h0, fe.if_to_ib_bus[65]}, 66'h0);

    // Branch under a 3-cycle stall is deferred
    step(1'b0, 1'b0, 32'h0, 6'h01, {1'b1, 32'hBFC0_0200});
    step(1'b0, 1'b0, 32'h0, 6'h03, 33'h0);
    step(1'b0, 1'b0, 32'h0, 6'h01, 33'h0);
    free(1);
    chk("pend_pc", {34'h0, fe.if_to_ib_bus[63:32]}, {34'h0, 32'hBFC0_0200});
    chk("pend_disc", {65'h0, fe.if_to_ib_bus[65]}, 66'h1);
    free(1);

    // Flush beats same-cycle branch and stall; pending branch dropped
    step(1'b0, 1'b0, 32'h0, 6'h01, {1'b1, 32'hBFC0_0444});
    step(1'b0, 1'b1, 32'hBFC0_0380, 6'h01, {1'b1, 32'hBFC0_0500});
    chk("flush_pc", {34'h0, fe.if_to_ib_bus[63:32]}, {34'h0, 32'hBFC0_0380});
    chk("flush_disc", {65'h0, fe.if_to_ib_bus[65]}, 66'h0);
    free(2);

    // Wrap-around at top of address space
    step(1'b0, 1'b1, 32'hFFFF_FFF0, 6'h0, 33'h0);
    free(2);
    chk("wrap_pc", {34'h0, fe.if_to_ib_bus[63:32]}, 66'h0);
    chk("wrap_ce", {65'h0, fe.if_to_ib_bus[64]}, 66'h1);
    free(1);

    // Reset while a branch is pending
    step(1'b0, 1'b0, 32'h0, 6'h01, {1'b1, 32'hBFC0_0600});
    step(1'b1, 1'b0, 32'h0, 6'h01, 33'h0);
    free(3);
    chk("rst_pend_pc", {34'h0, fe.if_to_ib_bus[63:32]}, {34'h0, 32'hBFC0_0010});

    // Misaligned upper-word target
    step(1'b0, 1'b0, 32'h0, 6'h0, {1'b1, 32'h0000_1236});
    free(1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 99) < 2);
      f  = ($urandom_range(0, 99) < 5);
      np = $urandom();
      st = ($urandom_range(0, 99) < 35) ? 6'($urandom()) : 6'h0;
      br = {($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0, 32'($urandom())};
      step(r, f, np, st, br);
    end
    free(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
